// File: rtl/debounce_multi_pkg.sv
// Shared types and helpers for the multi-channel debouncer.
// Holds counter-width arithmetic and the per-channel event bundle.
package debounce_multi_pkg;

  // Bits needed to hold values 0..value-1, never less than one bit.
  function automatic int clog2(input longint value);
    int r;
    r = 0;
    while ((64'(1) << r) < value) r++;
    return (r < 1) ? 1 : r;
  endfunction

  typedef struct packed {
    logic press_ev;
    logic release_ev;
    logic long_ev;
  } ch_evt_t;

  localparam int EVT_W = $bits(ch_evt_t);

endpackage

// File: rtl/debounce_multi_if.sv
// Pin-side and user-side signals of the debouncer, grouped in one bundle.
// The master drives the raw pins; the debouncer (slave) drives the cleaned outputs.
interface debounce_multi_if #(
  parameter int CH = 4
);

  logic [CH-1:0] noisy_in;
  logic [CH-1:0] stable_out;
  logic [CH-1:0] press_pulse;
  logic [CH-1:0] release_pulse;
  logic [CH-1:0] long_pulse;
  logic          any_active;

  modport master (
    output noisy_in,
    input  stable_out,
    input  press_pulse,
    input  release_pulse,
    input  long_pulse,
    input  any_active
  );

  modport slave (
    input  noisy_in,
    output stable_out,
    output press_pulse,
    output release_pulse,
    output long_pulse,
    output any_active
  );

endinterface

// File: rtl/debounce_multi_ch.sv
// One debouncer channel: synchroniser, persistence filter and event pulses.
// The filter holds the last settled level while the pin bounces.
module debounce_ch
  import debounce_multi_pkg::*;
#(
  parameter int LAST_CYCLES = 2_000_000,
  parameter int SYNC_STAGES = 2,
  parameter bit ACTIVE_LOW  = 1'b0,
  parameter int LONG_CYCLES = 100_000_000
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    pin,
  output logic    stable,
  output ch_evt_t evt
);

  localparam int            FW     = clog2(LAST_CYCLES + 1);
  localparam logic [FW-1:0] F_LAST = FW'(LAST_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic [FW-1:0]          filt_cnt_reg;
  logic                   stable_reg;
  logic                   press_reg;
  logic                   release_reg;
  logic                   long_w;
  logic                   level;
  logic                   flip;

  // Idle pin level at reset keeps the first filtered sample equal to stable_reg.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_reg <= {SYNC_STAGES{ACTIVE_LOW}};
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], pin};
    end
  end

  assign level = sync_reg[SYNC_STAGES-1] ^ ACTIVE_LOW;
  assign flip  = (level != stable_reg) && (filt_cnt_reg == F_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_cnt_reg <= '0;
      stable_reg   <= 1'b0;
      press_reg    <= 1'b0;
      release_reg  <= 1'b0;
    end else begin
      press_reg   <= flip & level;
      release_reg <= flip & ~level;
      if (level == stable_reg || flip) begin
        filt_cnt_reg <= '0;
      end else begin
        filt_cnt_reg <= filt_cnt_reg + 1'b1;
      end
      if (flip) begin
        stable_reg <= level;
      end
    end
  end

  generate
    if (LONG_CYCLES > 0) begin : g_long
      localparam int            HW    = clog2(LONG_CYCLES + 1);
      localparam logic [HW-1:0] H_MAX = HW'(LONG_CYCLES);
      localparam logic [HW-1:0] H_PRE = HW'(LONG_CYCLES - 1);

      logic [HW-1:0] hold_cnt_reg;
      logic          long_reg;

      // Saturating at H_MAX makes the pulse fire only once per press.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          hold_cnt_reg <= '0;
          long_reg     <= 1'b0;
        end else begin
          long_reg <= stable_reg && (hold_cnt_reg == H_PRE);
          if (!stable_reg) begin
            hold_cnt_reg <= '0;
          end else if (hold_cnt_reg != H_MAX) begin
            hold_cnt_reg <= hold_cnt_reg + 1'b1;
          end
        end
      end

      assign long_w = long_reg;
    end else begin : g_no_long
      assign long_w = 1'b0;
    end
  endgenerate

  assign stable = stable_reg;
  assign evt    = '{press_ev: press_reg, release_ev: release_reg, long_ev: long_w};

endmodule

// File: rtl/debounce_multi.sv
// N-channel button/switch debouncer: one independent debounce_ch per pin
// plus an any-channel-pressed summary.
module debounce_multi
  import debounce_multi_pkg::*;
#(
  parameter int            CH          = 4,
  parameter int            LAST_CYCLES = 2_000_000,
  parameter int            SYNC_STAGES = 2,
  parameter logic [CH-1:0] ACTIVE_LOW  = '0,
  parameter int            LONG_CYCLES = 100_000_000
) (
  input logic               clk,
  input logic               rst_n,
  debounce_multi_if.slave   bus
);

  ch_evt_t       evt_w [CH];
  logic [CH-1:0] stable_w;
  logic [CH-1:0] press_w;
  logic [CH-1:0] release_w;
  logic [CH-1:0] long_w;

  generate
    for (genvar gi = 0; gi < CH; gi++) begin : g_ch
      debounce_ch #(
        .LAST_CYCLES (LAST_CYCLES),
        .SYNC_STAGES (SYNC_STAGES),
        .ACTIVE_LOW  (ACTIVE_LOW[gi]),
        .LONG_CYCLES (LONG_CYCLES)
      ) u_ch (
        .clk    (clk),
        .rst_n  (rst_n),
        .pin    (bus.noisy_in[gi]),
        .stable (stable_w[gi]),
        .evt    (evt_w[gi])
      );

      assign press_w[gi]   = evt_w[gi].press_ev;
      assign release_w[gi] = evt_w[gi].release_ev;
      assign long_w[gi]    = evt_w[gi].long_ev;
    end
  endgenerate

  assign bus.stable_out    = stable_w;
  assign bus.press_pulse   = press_w;
  assign bus.release_pulse = release_w;
  assign bus.long_pulse    = long_w;
  assign bus.any_active    = |stable_w;

endmodule

// File: tb/tb_debounce_multi.sv
// Randomised and directed bench for debounce_multi, checked cycle by cycle
// against a window-based reference model of the debounce rules.
module tb_debounce_multi;

  localparam int            CH    = 2;
  localparam int            LAST  = 4;
  localparam int            SYNC  = 2;
  localparam int            LONG  = 10;
  localparam logic [CH-1:0] AL    = 2'b10;
  localparam int            DEPTH = SYNC + LAST;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  debounce_multi_if #(.CH(CH)) bus ();

  debounce_multi #(
    .CH          (CH),
    .LAST_CYCLES (LAST),
    .SYNC_STAGES (SYNC),
    .ACTIVE_LOW  (AL),
    .LONG_CYCLES (LONG)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // Reference model: last DEPTH pin vectors; the oldest LAST entries are
  // the synchronised samples the filter judges at this edge.
  logic [CH-1:0] pin_q [$];
  logic [CH-1:0] m_stable, m_press, m_rel, m_long;
  int            press_cyc [CH];

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @cycle %0d: got %0h, expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    m_stable = '0;
    m_press  = '0;
    m_rel    = '0;
    m_long   = '0;
    pin_q.delete();
    for (int i = 0; i < DEPTH; i++) pin_q.push_back(AL);
    for (int c = 0; c < CH; c++) press_cyc[c] = -1;
  endtask

  task automatic model_edge(input logic [CH-1:0] pin);
    logic [CH-1:0] v;
    bit            all_new;
    pin_q.push_back(pin);
    void'(pin_q.pop_front());
    m_press = '0;
    m_rel   = '0;
    m_long  = '0;
    for (int c = 0; c < CH; c++) begin
      // Long press: pressed LONG cycles ago and never released since.
      if (press_cyc[c] >= 0 && cyc == press_cyc[c] + LONG) m_long[c] = 1'b1;
      all_new = 1'b1;
      for (int j = 0; j < LAST; j++) begin
        v = pin_q[j];
        if ((v[c] ^ AL[c]) == m_stable[c]) all_new = 1'b0;
      end
      if (all_new) begin
        m_stable[c] = ~m_stable[c];
        if (m_stable[c]) begin
          m_press[c]   = 1'b1;
          press_cyc[c] = cyc;
        end else begin
          m_rel[c]     = 1'b1;
          press_cyc[c] = -1;
        end
      end
    end
  endtask

  task automatic check_outputs();
    check("stable_out",    8'(bus.stable_out),    8'(m_stable));
    check("press_pulse",   8'(bus.press_pulse),   8'(m_press));
    check("release_pulse", 8'(bus.release_pulse), 8'(m_rel));
    check("long_pulse",    8'(bus.long_pulse),    8'(m_long));
    check("any_active",    8'(bus.any_active),    8'(|m_stable));
  endtask

  task automatic step(input logic [CH-1:0] pin);
    bus.noisy_in = pin;
    @(posedge clk);
    cyc++;
    model_edge(pin);
    #1;
    check_outputs();
  endtask

  task automatic run(input logic [CH-1:0] pin, input int n);
    for (int i = 0; i < n; i++) step(pin);
  endtask

  task automatic mid_reset(input logic [CH-1:0] pin);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    repeat (3) @(posedge clk);
    bus.noisy_in = pin;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic phase_done(input string name, input int start_vec);
    $display("phase %-10s cycle=%0d vectors=%0d", name, cyc, n_vec - start_vec);
  endtask

  initial begin
    int            v0;
    int            runlen [CH];
    logic [CH-1:0] lvl;

    bus.noisy_in = AL;
    model_reset();
    repeat (4) @(posedge clk);
    #1;
    check_outputs();
    @(negedge clk);
    rst_n = 1'b1;

    v0 = n_vec; run(2'b10, 50);                 phase_done("idle", v0);
    v0 = n_vec; run(2'b11, 12); run(2'b10, 10); phase_done("press_ch0", v0);

    v0 = n_vec;
    for (int i = 0; i < 40; i++) step({1'b1, (i % 4) != 3});
    run(2'b10, 8);
    phase_done("bounce", v0);

    v0 = n_vec; run(2'b00, 30); run(2'b10, 10); phase_done("long_ch1", v0);
    v0 = n_vec; run(2'b01, 20); run(2'b10, 10); phase_done("both", v0);

    v0 = n_vec;
    run(2'b01, 15);
    mid_reset(2'b01);
    run(2'b01, 12);
    run(2'b10, 10);
    phase_done("mid_reset", v0);

    v0 = n_vec;
    lvl = AL;
    for (int c = 0; c < CH; c++) runlen[c] = 0;
    for (int i = 0; i < 3000; i++) begin
      for (int c = 0; c < CH; c++) begin
        if (runlen[c] == 0) begin
          lvl[c]    = ~lvl[c];
          runlen[c] = ($urandom_range(0, 3) == 0) ? $urandom_range(5, 20) : $urandom_range(1, 5);
        end
        runlen[c]--;
      end
      if (i == 1000 || i == 2200) mid_reset(lvl);
      step(lvl);
    end
    phase_done("random", v0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/debounce_multi.md
Name: debounce_multi

Overview:
- Parameterised N-channel debouncer for buttons and switches: metastability synchroniser, persistence filter, and press/release/long-press event pulses per channel.
- Successor to the single-channel debouncer. Adds configurable channel count, per-channel input polarity, a synchroniser, and a held output instead of forcing 0 while unsettled.
- Sits between board pins and user logic (FSMs, counters) in lab top-levels.

Parameters:
- CH, 4, number of independent channels (>=1).
- LAST_CYCLES, 2_000_000, consecutive synchronised cycles an input must hold a new level before stable_out follows (>=1).
- SYNC_STAGES, 2, synchroniser flops per channel (>=2).
- ACTIVE_LOW, {CH{1'b0}}, per-channel mask; bit=1 means the pin reads 0 when pressed and is inverted at input.
- LONG_CYCLES, 100_000_000, cycles stable_out must stay 1 before long_pulse fires; 0 disables long-press.

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset, asynchronous, active-low
- noisy_in  input  CH  raw asynchronous pin levels
- stable_out  output  CH  debounced level, 1 = pressed (polarity-corrected)
- press_pulse  output  CH  1-cycle pulse on stable_out 0->1
- release_pulse  output  CH  1-cycle pulse on stable_out 1->0
- long_pulse  output  CH  1-cycle pulse when held pressed for LONG_CYCLES
- any_active  output  1  OR-reduction of stable_out

Behaviour:
- Reset values:
  - All outputs 0.
  - Synchroniser flops load the idle pin level (ACTIVE_LOW[i]), so no spurious event follows reset release.
  - All counters 0.
- Polarity: sampled level s[i] = sync_out[i] XOR ACTIVE_LOW[i].
- Filter counter per channel, width clog2(LAST_CYCLES+1):
  - If s == stable_out: counter <= 0.
  - Else if counter == LAST_CYCLES-1: stable_out <= s, counter <= 0.
  - Else: counter increments.
  - Any single-cycle return to the stable level restarts the count. No partial credit.
- Latency: a clean pin edge reaches stable_out exactly SYNC_STAGES+LAST_CYCLES clock edges later.
- stable_out holds its last settled value during bounce. It never drops to 0 while the input is unsettled.
- Event pulses:
  - press_pulse and release_pulse are registered and asserted in the same cycle stable_out first shows its new value.
  - Exactly one pulse per transition; never both in one cycle on one channel.
- Long-press:
  - Hold counter per channel, width clog2(LONG_CYCLES+1), clears when stable_out = 0.
  - Increments while stable_out = 1 and saturates at LONG_CYCLES.
  - long_pulse fires in the cycle the counter reaches LONG_CYCLES (i.e. LONG_CYCLES cycles after press_pulse) and only once per press.
  - If LONG_CYCLES = 0, long_pulse is tied 0 and the hold logic is removed.
- Channels are fully independent. Simultaneous events on several channels all pulse in the same cycle.
- Reset mid-operation clears all counters and outputs asynchronously. No release_pulse is generated for a channel that was pressed.
- Counters never wrap: the filter counter tops out at LAST_CYCLES-1, the hold counter saturates.

Decomposition:
- Shared package/header: clog2 constant function and the channel event bundle width constant.
- Sub-module debounce_ch holds one channel: synchroniser, filter, edge/long logic.
- debounce_multi is a generate loop over CH instances plus the any_active reduction.

Test Plan (CH=2, LAST_CYCLES=4, SYNC_STAGES=2, LONG_CYCLES=10, ACTIVE_LOW=2'b10):
- Reset and idle: rst_n low, then noisy_in=2'b10 -> all outputs 0 for 50 cycles, no pulses.
- Clean press on ch0: noisy_in[0] 0->1 at edge t -> stable_out[0]=1 and press_pulse[0]=1 at t+6 only; any_active=1 from t+6.
- Bounce rejection on ch0: toggle noisy_in[0] with high runs of 3 cycles separated by 1-cycle lows, for 40 cycles -> stable_out[0] stays 0, no pulses.
- Active-low ch1 with long press: drive noisy_in[1]=0 and hold 30 cycles -> press_pulse[1] at +6, long_pulse[1] 10 cycles after that, exactly once; release (1) -> release_pulse[1] 6 cycles later.
- Simultaneous: press both channels in the same cycle -> press_pulse=2'b11 in a single cycle.
- Reset mid-press: both pressed, assert rst_n -> all outputs 0 immediately; deassert with pins still pressed -> fresh press_pulse after 6 cycles, not earlier.
